// File: rtl/risc_wb_pkg.sv
// Shared widths and payload type for the register-file writeback path.
package risc_wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Writeback bus: ALU and load result inputs, register-file write port, pending mask.
interface reg_writeback_ctrl_if
  import risc_wb_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned DATA_W = REG_DATA_W
);

  logic                    alu_valid;
  logic [ADDR_W-1:0]       alu_addr;
  logic [DATA_W-1:0]       alu_data;
  logic                    alu_stall;
  logic                    mem_valid;
  logic                    mem_ready;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_data;
  logic                    wb_we;
  logic [ADDR_W-1:0]       wb_addr;
  logic [DATA_W-1:0]       wb_data;
  logic [(1<<ADDR_W)-1:0]  pending;

  // Result producers and register-file observer
  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_stall, mem_ready, wb_we, wb_addr, wb_data, pending
  );

  // Writeback controller
  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_stall, mem_ready, wb_we, wb_addr, wb_data, pending
  );

endinterface

// File: rtl/wb_dual_push_fifo.sv
// In-order {addr,data} queue with two push ports (push0 older than push1) and one pop port.
module wb_dual_push_fifo
  import risc_wb_pkg::*;
#(
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned ADDR_W = REG_ADDR_W,
  parameter  int unsigned DATA_W = REG_DATA_W,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push0,
  input  logic [ADDR_W-1:0]             push0_addr,
  input  logic [DATA_W-1:0]             push0_data,
  input  logic                          push1,
  input  logic [ADDR_W-1:0]             push1_addr,
  input  logic [DATA_W-1:0]             push1_data,
  input  logic                          pop,
  output logic [ADDR_W-1:0]             head_addr,
  output logic [DATA_W-1:0]             head_data,
  output logic [CNT_W-1:0]              occ,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop_ok;
  logic [PTR_W-1:0]  push1_ptr;

  assign pop_ok    = pop && (occ != '0);
  assign push1_ptr = wr_ptr + PTR_W'(push0);

  // Storage has no reset; validity is tracked by occ and rd_ptr
  always_ff @(posedge clk) begin
    if (push0) begin
      addr_mem[wr_ptr] <= push0_addr;
      data_mem[wr_ptr] <= push0_data;
    end
    if (push1) begin
      addr_mem[push1_ptr] <= push1_addr;
      data_mem[push1_ptr] <= push1_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
      rd_ptr <= rd_ptr + PTR_W'(pop_ok);
      occ    <= occ + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop_ok);
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Slot i is live when its distance from the head is below the occupancy
  always_comb begin
    entry_valid = '0;
    entry_addr  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_valid[i] = {1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < occ;
      entry_addr[i]  = addr_mem[i];
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write initiator: queues ALU/load results in order, one write per cycle.
// Optional macro WB_ZERO_DISCARD_EN: accept but drop writes to register 0.
module reg_writeback_ctrl
  import risc_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_writeback_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]             occ;
  logic [CNT_W-1:0]             free;
  logic                         alu_acc;
  logic                         mem_acc;
  logic                         alu_push;
  logic                         mem_push;
  logic [ADDR_W-1:0]            head_addr;
  logic [DATA_W-1:0]            head_data;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;
  logic [(1<<ADDR_W)-1:0]       pend;

  // Handshake is derived from stored occupancy only; a same-cycle pop frees nothing
  assign free          = CNT_W'(DEPTH) - occ;
  assign bus.alu_stall = free < CNT_W'(2);
  assign bus.mem_ready = bus.alu_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1));
  assign alu_acc       = bus.alu_valid && !bus.alu_stall;
  assign mem_acc       = bus.mem_valid && bus.mem_ready;

`ifdef WB_ZERO_DISCARD_EN
  assign alu_push = alu_acc && (bus.alu_addr != '0);
  assign mem_push = mem_acc && (bus.mem_addr != '0);
`else
  assign alu_push = alu_acc;
  assign mem_push = mem_acc;
`endif

  wb_dual_push_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push0       (alu_push),
    .push0_addr  (bus.alu_addr),
    .push0_data  (bus.alu_data),
    .push1       (mem_push),
    .push1_addr  (bus.mem_addr),
    .push1_data  (bus.mem_data),
    .pop         (occ != '0),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .occ         (occ),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // Write-port registers: present the head whenever something is stored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.wb_we   <= 1'b0;
      bus.wb_addr <= '0;
      bus.wb_data <= '0;
    end else if (occ != '0) begin
      bus.wb_we   <= 1'b1;
      bus.wb_addr <= head_addr;
      bus.wb_data <= head_data;
    end else begin
      bus.wb_we   <= 1'b0;
    end
  end

  // Destinations still in flight: queued entries plus the write being presented
  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pend[entry_addr[i]] = 1'b1;
    end
    if (bus.wb_we) pend[bus.wb_addr] = 1'b1;
    bus.pending = pend;
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl (DEPTH=4, 5-bit addresses, 32-bit data).
module tb_reg_writeback_ctrl;
  import risc_wb_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  reg_writeback_ctrl_if #(.ADDR_W(REG_ADDR_W), .DATA_W(REG_DATA_W)) bus ();

  reg_writeback_ctrl #(.DEPTH(4), .DATA_W(REG_DATA_W), .ADDR_W(REG_ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input wb_entry_t a, input logic mv, input wb_entry_t m);
    bus.alu_valid = av;
    bus.alu_addr  = a.addr;
    bus.alu_data  = a.data;
    bus.mem_valid = mv;
    bus.mem_addr  = m.addr;
    bus.mem_data  = m.data;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0);
  endtask

  function automatic wb_entry_t e(input int unsigned addr, input int unsigned data);
    wb_entry_t r;
    r.addr = REG_ADDR_W'(addr);
    r.data = REG_DATA_W'(data);
    return r;
  endfunction

  function automatic logic [31:0] bit_of(input int unsigned r);
    logic [31:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic check_wb(input string tag, input logic we, input int unsigned addr, input int unsigned data);
    check({tag, "_we"}, 64'(bus.wb_we), 64'(we));
    check({tag, "_addr"}, 64'(bus.wb_addr), 64'(addr));
    check({tag, "_data"}, 64'(bus.wb_data), 64'(data));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    idle();
    #10;
    check("rst_we", 64'(bus.wb_we), 64'd0);
    check("rst_addr", 64'(bus.wb_addr), 64'd0);
    check("rst_data", 64'(bus.wb_data), 64'd0);
    check("rst_pending", 64'(bus.pending), 64'd0);
    check("rst_stall", 64'(bus.alu_stall), 64'd0);
    check("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
    reset = 1'b1;
    tick();

    // ALU-only write of r5
    drive(1'b1, e(5, 32'h1234), 1'b0, '0);
    tick();
    idle();
    check("alu_pend_c0", 64'(bus.pending), 64'(bit_of(5)));
    check("alu_we_c0", 64'(bus.wb_we), 64'd0);
    tick();
    check_wb("alu_c1", 1'b1, 5, 32'h1234);
    check("alu_pend_c1", 64'(bus.pending), 64'(bit_of(5)));
    tick();
    check("alu_we_c2", 64'(bus.wb_we), 64'd0);
    check("alu_pend_c2", 64'(bus.pending), 64'd0);

    // Dual push: ALU entry is older than mem entry
    drive(1'b1, e(1, 32'hA), 1'b1, e(2, 32'hB));
    check("dual_mem_ready", 64'(bus.mem_ready), 64'd1);
    tick();
    idle();
    check("dual_pend_c0", 64'(bus.pending), 64'(bit_of(1) | bit_of(2)));
    tick();
    check_wb("dual_c1", 1'b1, 1, 32'hA);
    tick();
    check_wb("dual_c2", 1'b1, 2, 32'hB);
    tick();
    check("dual_we_c3", 64'(bus.wb_we), 64'd0);

    // Back-pressure: two dual pushes, then a held (ignored) dual request
    drive(1'b1, e(1, 32'h11), 1'b1, e(2, 32'h22));
    tick();
    drive(1'b1, e(3, 32'h33), 1'b1, e(4, 32'h44));
    check("bp_stall_occ2", 64'(bus.alu_stall), 64'd0);
    check("bp_ready_occ2", 64'(bus.mem_ready), 64'd1);
    tick();
    drive(1'b1, e(5, 32'h55), 1'b1, e(6, 32'h66));
    check("bp_stall_occ3", 64'(bus.alu_stall), 64'd1);
    check("bp_ready_occ3", 64'(bus.mem_ready), 64'd0);
    check_wb("bp_c1", 1'b1, 1, 32'h11);
    tick();
    check("bp_stall_clear", 64'(bus.alu_stall), 64'd0);
    check_wb("bp_c2", 1'b1, 2, 32'h22);
    idle();
    check("bp_ready_idle", 64'(bus.mem_ready), 64'd1);
    check("bp_pend_c2", 64'(bus.pending), 64'(bit_of(2) | bit_of(3) | bit_of(4)));
    tick();
    check_wb("bp_c3", 1'b1, 3, 32'h33);
    tick();
    check_wb("bp_c4", 1'b1, 4, 32'h44);
    tick();
    check("bp_we_c5", 64'(bus.wb_we), 64'd0);
    check("bp_pend_c5", 64'(bus.pending), 64'd0);

    // Mem-only push
    drive(1'b0, '0, 1'b1, e(12, 32'hC0));
    check("mem_only_ready", 64'(bus.mem_ready), 64'd1);
    tick();
    idle();
    tick();
    check_wb("mem_only_c1", 1'b1, 12, 32'hC0);
    tick();

    // Asynchronous reset with three entries queued and a write presented
    drive(1'b1, e(8, 32'h80), 1'b1, e(9, 32'h90));
    tick();
    drive(1'b1, e(10, 32'hA0), 1'b1, e(11, 32'hB0));
    tick();
    idle();
    check("ar_we_before", 64'(bus.wb_we), 64'd1);
    check("ar_pend_before", 64'(bus.pending),
          64'(bit_of(8) | bit_of(9) | bit_of(10) | bit_of(11)));
    #1 reset = 1'b0;
    #1;
    check("ar_we", 64'(bus.wb_we), 64'd0);
    check("ar_addr", 64'(bus.wb_addr), 64'd0);
    check("ar_pending", 64'(bus.pending), 64'd0);
    check("ar_stall", 64'(bus.alu_stall), 64'd0);
    check("ar_mem_ready", 64'(bus.mem_ready), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    check("ar_we_post1", 64'(bus.wb_we), 64'd0);
    tick();
    check("ar_we_post2", 64'(bus.wb_we), 64'd0);
    check("ar_pend_post2", 64'(bus.pending), 64'd0);

    // Duplicate destination r7
    drive(1'b1, e(7, 32'h1), 1'b0, '0);
    tick();
    drive(1'b1, e(7, 32'h2), 1'b0, '0);
    check("dup_pend_c0", 64'(bus.pending), 64'(bit_of(7)));
    tick();
    idle();
    check_wb("dup_c1", 1'b1, 7, 32'h1);
    check("dup_pend_c1", 64'(bus.pending), 64'(bit_of(7)));
    tick();
    check_wb("dup_c2", 1'b1, 7, 32'h2);
    check("dup_pend_c2", 64'(bus.pending), 64'(bit_of(7)));
    tick();
    check("dup_we_c3", 64'(bus.wb_we), 64'd0);
    check("dup_pend_c3", 64'(bus.pending), 64'd0);

    // Register 0 write
    drive(1'b1, e(0, 32'hFF), 1'b0, '0);
    check("zero_stall", 64'(bus.alu_stall), 64'd0);
    tick();
    idle();
`ifdef WB_ZERO_DISCARD_EN
    check("zero_pend_c0", 64'(bus.pending), 64'd0);
    tick();
    check_wb("zero_c1", 1'b0, 7, 32'h2);
    check("zero_pend_c1", 64'(bus.pending), 64'd0);
`else
    check("zero_pend_c0", 64'(bus.pending), 64'(bit_of(0)));
    tick();
    check_wb("zero_c1", 1'b1, 0, 32'hFF);
    check("zero_pend_c1", 64'(bus.pending), 64'(bit_of(0)));
`endif
    tick();
    check("zero_we_c2", 64'(bus.wb_we), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback_ctrl.md
# reg_writeback_ctrl

Register-file write initiator for the RISC CPU core. It accepts results from the single-cycle ALU path and the multi-cycle load/memory path, buffers them in order in a small queue, and drives the register file's single write port with at most one write per cycle. It also exports a pending-write mask so decode can stall on registers with writes still in flight.

## Interface
Parameters:
- DEPTH, 4, queue entries (power of two, ≥ 2)
- DATA_W, 32, result/register width
- ADDR_W, 5, register address width

Ports:
- clk  in  1  core clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_stall  out  1  queue cannot guarantee two free slots; ALU pipeline must hold
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted this cycle when mem_valid is high
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- wb_we  out  1  register-file write enable
- wb_addr  out  ADDR_W  register-file write address
- wb_data  out  DATA_W  register-file write data
- pending  out  2^ADDR_W  bit r set while any write to register r is queued or presented on wb_*

## Operation
- Queue: in-order FIFO of {addr, data}. Up to two pushes and one pop per cycle.
- occ = stored occupancy; free = DEPTH − occ. Both are computed from registered state only. A pop in the same cycle does not free a slot until the next cycle.
- alu_stall = (free < 2), combinational from registered state.
- mem_ready = alu_valid ? (free ≥ 2) : (free ≥ 1).
- Push rules:
  - alu_valid with alu_stall low is accepted.
  - alu_valid while alu_stall is high is a protocol violation and is ignored.
  - The mem transfer occurs when mem_valid && mem_ready.
  - If both push in the same cycle, the ALU entry is written first (older), then the mem entry.
- Pop: each posedge, if occ > 0, the head moves into the wb_addr/wb_data registers and wb_we is set to 1. Otherwise wb_we is set to 0 and wb_addr/wb_data hold their values.
- Entries pushed at an edge are not eligible to pop at that same edge.
- pending is the OR of one-hot(addr) over every valid queue entry, plus one-hot(wb_addr) when wb_we is 1. It is combinational from registered state.
- Duplicate destinations are allowed. Writes leave in push order, so the last value wins in the register file.
- Pointers are log2(DEPTH) bits and wrap naturally. The count register is log2(DEPTH)+1 bits.

## Timing
- Latency: a result accepted at edge N appears on wb_* after edge N+1 (wb_we high during cycle N+1). The register file commits it at edge N+2.
- Throughput: one write per cycle. With two pushes per cycle, occupancy grows by 1 per cycle.
- Reset (reset low, asynchronous):
  - wb_we=0, wb_addr=0, wb_data=0.
  - Queue emptied (occ=0, pointers 0).
  - pending=0, alu_stall=0, mem_ready=1.
- Reset mid-operation discards all queued and presented writes. No write is issued after reset releases until a new push occurs.
- Full: with occ=DEPTH, both ports are blocked and a pop still occurs.
- Empty: with occ=0, wb_we=0 on the next cycle.

## Configuration
- WB_ZERO_DISCARD_EN defined: pushes with addr 0 are accepted (handshake completes, ALU is not stalled by them), but they are not enqueued. They never assert wb_we and never set pending[0].
- WB_ZERO_DISCARD_EN undefined: register 0 is written like any other register.

## Structure
- Package risc_wb_pkg holds:
  - REG_ADDR_W=5 and REG_DATA_W=32
  - typedef wb_entry_t {addr, data}
- Sub-module wb_dual_push_fifo: storage, pointers and occupancy, with two push ports, one pop port, and an entry-valid vector for building pending.
- reg_writeback_ctrl contains the handshake logic, the wb_* output registers, the pending mask and the zero-discard filter.

## Test plan
- ALU-only write: ALU writes r5=0x00001234 at edge 0 → wb_we=1, wb_addr=5, wb_data=0x1234 during cycle 1 only; pending[5] high during cycles 0 and 1.
- Dual push: ALU r1=0xA and mem r2=0xB at the same edge → r1 presented during cycle 1, r2 during cycle 2; mem_ready=1.
- Back-pressure, DEPTH=4: both ports push on two consecutive edges.
  - alu_stall=1 and mem_ready=0 once free<2.
  - The queue drains r-entries in push order.
  - alu_stall clears the cycle after occ ≤ 2.
- Async reset: assert reset low with 3 entries queued and wb_we=1 → wb_we, pending and occ drop to 0 immediately; no write occurs after release.
- Duplicate destination: r7=0x1 then r7=0x2 → two writes in order; pending[7] stays high until the second write's cycle ends.
- Zero register: ALU writes r0=0xFF → with WB_ZERO_DISCARD_EN, wb_we stays 0 and pending[0] stays 0; without it, wb_we=1 with wb_addr=0.
